// File: rtl/riscv16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv16_pkg
// Description : Shared constants and types for the 16-bit core: data width,
//               register index width and the write-back request record.
// Revision    : 1.0  initial release
// ============================================================================
package riscv16_pkg;

    localparam int XLEN  = 16;
    localparam int NREGS = 8;
    localparam int AW    = 3;

    typedef logic [AW-1:0] reg_idx_t;

    // One result offered to the register-file write port
    typedef struct packed {
        logic            valid;
        reg_idx_t        tgt;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage : riscv16_pkg
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Two-source priority arbiter for the write-back port. The LSU
//               normally wins; after STARVE_LIMIT consecutive ALU denials the
//               ALU is given priority for one cycle.
// Revision    : 1.0  initial release
// ============================================================================
module wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic alu_valid,
    input  logic lsu_valid,
    output logic grant_alu,
    output logic grant_lsu
);

    localparam int              c_cnt_w = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(STARVE_LIMIT);

    logic [c_cnt_w-1:0] r_starve_cnt;
    logic               w_alu_pri;

    assign w_alu_pri = (r_starve_cnt == c_limit);

    // Grants are already qualified by valid; nothing is granted during reset
    always_comb begin
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        if (!rst) begin
            if (alu_valid && (!lsu_valid || w_alu_pri)) begin
                grant_alu = 1'b1;
            end else if (lsu_valid) begin
                grant_lsu = 1'b1;
            end
        end
    end

    // Count consecutive cycles in which a waiting ALU result lost to the LSU
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (!alu_valid || grant_alu) begin
            r_starve_cnt <= '0;
        end else if (grant_lsu && (r_starve_cnt != c_limit)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

endmodule : wb_arbiter
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module      : regfile_writeback
// Description : Write-back stage for the 8x16 register file. Arbitrates ALU
//               and LSU results onto the single write port, tracks pending
//               writes per register for RAW stalls and forwards the in-flight
//               write to the two decode read ports.
// Revision    : 1.0  initial release
// ============================================================================
module regfile_writeback #(
    parameter int XLEN         = 16,
    parameter int NREGS        = 8,
    parameter int AW           = 3,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [AW-1:0]    alu_tgt,
    input  logic [XLEN-1:0]  alu_data,
    input  logic             lsu_valid,
    output logic             lsu_ready,
    input  logic [AW-1:0]    lsu_tgt,
    input  logic [XLEN-1:0]  lsu_data,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_tgt,
    output logic             we_reg,
    output logic [AW-1:0]    tgt,
    output logic [XLEN-1:0]  write_data,
    output logic [NREGS-1:0] busy,
    input  logic [AW-1:0]    src1,
    input  logic [AW-1:0]    src2,
    output logic             fwd1_hit,
    output logic             fwd2_hit,
    output logic             err
);

    import riscv16_pkg::*;

    logic             w_alu_acc;
    logic             w_lsu_acc;
    wb_req_t          w_sel;
    logic             w_wr;
    logic [NREGS-1:0] w_set_mask;
    logic [NREGS-1:0] w_clr_mask;
    logic             w_waw;
    logic             w_orphan;

    logic [NREGS-1:0] r_busy;
    logic             r_we;
    logic [AW-1:0]    r_tgt;
    logic [XLEN-1:0]  r_data;
    logic             r_err;

    wb_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .lsu_valid (lsu_valid),
        .grant_alu (w_alu_acc),
        .grant_lsu (w_lsu_acc)
    );

    assign alu_ready = w_alu_acc;
    assign lsu_ready = w_lsu_acc;

    // Steer the accepted source onto the write request
    always_comb begin
        w_sel = '0;
        if (w_alu_acc) begin
            w_sel.valid = 1'b1;
            w_sel.tgt   = alu_tgt;
            w_sel.data  = alu_data;
        end else if (w_lsu_acc) begin
            w_sel.valid = 1'b1;
            w_sel.tgt   = lsu_tgt;
            w_sel.data  = lsu_data;
        end
    end

    // r0 results are consumed but never written and never tracked
    assign w_wr = w_sel.valid && (w_sel.tgt != '0);

    // One-hot set/clear masks for the pending-write scoreboard
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (issue_valid && (issue_tgt != '0)) begin
            w_set_mask[issue_tgt] = 1'b1;
        end
        if (w_wr) begin
            w_clr_mask[w_sel.tgt] = 1'b1;
        end
    end

    // WAW: re-issue to a register still pending; orphan: a write nobody issued
    assign w_waw    = issue_valid && (issue_tgt != '0) &&
                      r_busy[issue_tgt] && !w_clr_mask[issue_tgt];
    assign w_orphan = w_wr && !r_busy[w_sel.tgt];

    // Scoreboard update; a same-cycle set overrides the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
        end
    end

    // Commit register; tgt/data hold when nothing is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we   <= 1'b0;
            r_tgt  <= '0;
            r_data <= '0;
        end else begin
            r_we <= w_wr;
            if (w_sel.valid) begin
                r_tgt  <= w_sel.tgt;
                r_data <= w_sel.data;
            end
        end
    end

    // Sticky protocol-violation flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_waw || w_orphan) begin
            r_err <= 1'b1;
        end
    end

    assign we_reg     = r_we;
    assign tgt        = r_tgt;
    assign write_data = r_data;
    assign busy       = r_busy;
    assign err        = r_err;

    assign fwd1_hit = r_we && (r_tgt == src1) && (src1 != '0);
    assign fwd2_hit = r_we && (r_tgt == src2) && (src2 != '0);

endmodule : regfile_writeback
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_writeback
// Description : Scoreboard bench for regfile_writeback: directed scenarios
//               plus constrained-random traffic against a behavioural model.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_regfile_writeback;

    localparam int XLEN         = 16;
    localparam int NREGS        = 8;
    localparam int AW           = 3;
    localparam int STARVE_LIMIT = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             alu_valid, lsu_valid, issue_valid;
    logic             alu_ready, lsu_ready;
    logic [AW-1:0]    alu_tgt, lsu_tgt, issue_tgt, src1, src2, tgt;
    logic [XLEN-1:0]  alu_data, lsu_data, write_data;
    logic             we_reg, fwd1_hit, fwd2_hit, err;
    logic [NREGS-1:0] busy;

    always #5 clk = ~clk;

    regfile_writeback #(
        .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_tgt(alu_tgt), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_tgt(lsu_tgt), .lsu_data(lsu_data),
        .issue_valid(issue_valid), .issue_tgt(issue_tgt),
        .we_reg(we_reg), .tgt(tgt), .write_data(write_data), .busy(busy),
        .src1(src1), .src2(src2), .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .err(err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected per-cycle view and expected register-file writes
    typedef struct {
        logic       alu_rdy, lsu_rdy;
        logic [7:0] busy;
        logic       err, fwd1, fwd2, we;
    } cyc_t;
    typedef struct {
        logic [2:0]  tgt;
        logic [15:0] data;
    } com_t;

    cyc_t cyc_q[$];
    com_t com_q[$];
    bit   mon_en = 1'b0;

    // Reference model state
    logic [7:0] busy_m;
    bit         err_m;
    int         denials;
    bit         prev_we;
    logic [2:0] prev_tgt;
    bit         last_alu_acc, last_lsu_acc;

    task automatic model_clear();
        busy_m = '0; err_m = 1'b0; denials = 0;
        prev_we = 1'b0; prev_tgt = '0;
        last_alu_acc = 1'b0; last_lsu_acc = 1'b0;
        cyc_q.delete(); com_q.delete();
    endtask

    task automatic drive_idle();
        alu_valid = 1'b0; alu_tgt = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_tgt = '0; lsu_data = '0;
        issue_valid = 1'b0; issue_tgt = '0; src1 = '0; src2 = '0;
    endtask

    // One clock cycle of stimulus; the model predicts this cycle's outputs
    task automatic step(input logic av, input logic [2:0] at, input logic [15:0] ad,
                        input logic lv, input logic [2:0] lt, input logic [15:0] ld,
                        input logic iv, input logic [2:0] it,
                        input logic [2:0] s1, input logic [2:0] s2);
        cyc_t        e;
        com_t        c;
        bit          a_acc, l_acc, took;
        logic [2:0]  t;
        logic [15:0] d;
        @(posedge clk); #1;
        alu_valid = av; alu_tgt = at; alu_data = ad;
        lsu_valid = lv; lsu_tgt = lt; lsu_data = ld;
        issue_valid = iv; issue_tgt = it; src1 = s1; src2 = s2;

        a_acc = av && (!lv || (denials >= STARVE_LIMIT));
        l_acc = lv && !a_acc;
        took  = a_acc || l_acc;
        t     = a_acc ? at : lt;
        d     = a_acc ? ad : ld;

        e.alu_rdy = a_acc;
        e.lsu_rdy = l_acc;
        e.busy    = busy_m;
        e.err     = err_m;
        e.we      = prev_we;
        e.fwd1    = prev_we && (prev_tgt == s1) && (s1 != 0);
        e.fwd2    = prev_we && (prev_tgt == s2) && (s2 != 0);
        cyc_q.push_back(e);

        if (iv && it != 0 && busy_m[it] && !(took && t == it)) err_m = 1'b1;
        if (took && t != 0 && !busy_m[t]) err_m = 1'b1;
        if (!av || a_acc) denials = 0;
        else if (denials < STARVE_LIMIT) denials++;
        if (took && t != 0) begin
            busy_m[t] = 1'b0;
            c.tgt = t; c.data = d;
            com_q.push_back(c);
        end
        if (iv && it != 0) busy_m[it] = 1'b1;
        prev_we  = took && (t != 0);
        if (took) prev_tgt = t;
        last_alu_acc = a_acc;
        last_lsu_acc = l_acc;
        #1;
    endtask

    task automatic idle_step(input logic [2:0] s1, input logic [2:0] s2);
        step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, s1, s2);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        drive_idle();
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        model_clear();
        mon_en = 1'b1;
    endtask

    // Monitor: compare every cycle the bench issued against the model's view
    always @(negedge clk) begin
        cyc_t e;
        com_t c;
        if (mon_en && cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            chk("alu_ready", alu_ready, e.alu_rdy);
            chk("lsu_ready", lsu_ready, e.lsu_rdy);
            chk("busy", busy, e.busy);
            chk("err", err, e.err);
            chk("fwd1_hit", fwd1_hit, e.fwd1);
            chk("fwd2_hit", fwd2_hit, e.fwd2);
            chk("we_reg", we_reg, e.we);
            if (we_reg === 1'b1) begin
                if (com_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL commit: write to r%0d with no expected write", tgt);
                end else begin
                    c = com_q.pop_front();
                    chk("commit_tgt", tgt, c.tgt);
                    chk("commit_data", write_data, c.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] pat_alu;
        logic [2:0] lidx;
        bit         ah, lh;
        logic [2:0] at, lt, it, r;
        logic [15:0] ad, ld;
        logic       iv;

        // Reset state with both sources offering
        model_clear();
        drive_idle();
        rst = 1'b1;
        alu_valid = 1'b1; lsu_valid = 1'b1; alu_tgt = 3'd1; lsu_tgt = 3'd2;
        #13;
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_lsu_ready", lsu_ready, 0);
        chk("rst_we_reg", we_reg, 0);
        chk("rst_tgt", tgt, 0);
        chk("rst_write_data", write_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        do_reset();

        // Basic commit of r3
        step(0, 0, 0, 0, 0, 0, 1, 3'd3, 0, 0);
        step(1, 3'd3, 16'h1234, 0, 0, 0, 0, 0, 0, 0);
        chk("t1_alu_ready", alu_ready, 1);
        idle_step(0, 0);
        chk("t1_we_reg", we_reg, 1);
        chk("t1_tgt", tgt, 3);
        chk("t1_data", write_data, 16'h1234);
        chk("t1_busy3", busy[3], 0);

        // r0 target: consumed, never written
        step(0, 0, 0, 0, 0, 0, 1, 3'd0, 0, 0);
        step(1, 3'd0, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0);
        chk("t3_alu_ready", alu_ready, 1);
        idle_step(0, 0);
        chk("t3_we_reg", we_reg, 0);
        chk("t3_busy", busy, 0);
        chk("t3_err", err, 0);

        // Same-cycle set and clear of r5
        step(0, 0, 0, 0, 0, 0, 1, 3'd5, 0, 0);
        step(1, 3'd5, 16'h5555, 0, 0, 0, 1, 3'd5, 0, 0);
        idle_step(0, 0);
        chk("t4_busy5", busy[5], 1);
        chk("t4_err", err, 0);
        step(1, 3'd5, 16'h0055, 0, 0, 0, 0, 0, 0, 0);
        idle_step(0, 0);

        // Forwarding of the in-flight write
        step(0, 0, 0, 0, 0, 0, 1, 3'd2, 0, 0);
        step(1, 3'd2, 16'hBEEF, 0, 0, 0, 0, 0, 0, 0);
        idle_step(3'd2, 3'd0);
        chk("t5_fwd1", fwd1_hit, 1);
        chk("t5_fwd2", fwd2_hit, 0);
        chk("t5_data", write_data, 16'hBEEF);

        // Starvation: LSU x4, ALU x1, LSU again
        for (int k = 1; k < 8; k++) step(0, 0, 0, 0, 0, 0, 1, 3'(k), 0, 0);
        pat_alu = 6'b010000;
        lidx = 3'd2;
        for (int c = 0; c < 6; c++) begin
            step(1, (c <= 4) ? 3'd1 : 3'd7, 16'hA000 + 16'(c),
                 1, lidx, 16'hB000 + 16'(lidx), 0, 0, 0, 0);
            chk("t2_alu_ready", alu_ready, pat_alu[c]);
            chk("t2_lsu_ready", lsu_ready, !pat_alu[c]);
            if (!pat_alu[c]) lidx = lidx + 3'd1;
        end
        step(1, 3'd7, 16'h7777, 0, 0, 0, 0, 0, 0, 0);
        idle_step(0, 0);
        chk("t2_busy_drained", busy, 0);

        // Constrained-random legal traffic
        ah = 0; lh = 0; at = 0; lt = 0; ad = 0; ld = 0;
        for (int n = 0; n < 400; n++) begin
            if (!ah && $urandom_range(0, 1) == 1) begin
                r = 3'($urandom_range(0, 7));
                if (r == 0 || (busy_m[r] && !(lh && lt == r))) begin
                    ah = 1; at = r; ad = 16'($urandom);
                end
            end
            if (!lh && $urandom_range(0, 1) == 1) begin
                r = 3'($urandom_range(0, 7));
                if (r == 0 || (busy_m[r] && !(ah && at == r))) begin
                    lh = 1; lt = r; ld = 16'($urandom);
                end
            end
            iv = 1'($urandom_range(0, 1));
            it = 3'($urandom_range(0, 7));
            if (it != 0 && busy_m[it]) iv = 0;
            step(ah, at, ad, lh, lt, ld, iv, it,
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            if (last_alu_acc) ah = 0;
            if (last_lsu_acc) lh = 0;
        end
        idle_step(0, 0);
        chk("rand_err", err, 0);
        do_reset();

        // WAW makes err sticky; async reset clears everything mid-cycle
        step(0, 0, 0, 0, 0, 0, 1, 3'd4, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 3'd4, 0, 0);
        idle_step(0, 0);
        chk("t6_err_set", err, 1);
        idle_step(0, 0);
        idle_step(0, 0);
        chk("t6_err_hold", err, 1);
        step(0, 0, 0, 0, 0, 0, 1, 3'd6, 0, 0);
        step(1, 3'd6, 16'h6666, 0, 0, 0, 0, 0, 0, 0);
        step(1, 3'd0, 16'h0001, 1, 3'd0, 16'h0002, 0, 0, 3'd6, 3'd0);
        chk("t6_we_pre", we_reg, 1);
        mon_en = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_we", we_reg, 0);
        chk("t6_rst_tgt", tgt, 0);
        chk("t6_rst_data", write_data, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_err", err, 0);
        chk("t6_rst_alu_ready", alu_ready, 0);
        chk("t6_rst_lsu_ready", lsu_ready, 0);
        chk("t6_rst_fwd1", fwd1_hit, 0);
        @(posedge clk); #2;
        drive_idle();
        rst = 1'b0;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regfile_writeback
`default_nettype wire
